rowbias_shuffler: RTL and testbench
===================================

Name: rowbias_shuffler

Overview:
- Parametrised successor to the per-row bias bus.
- Holds a pool of W one-hot values and randomly permutes it with a Fisher-Yates shuffle driven by an internal LFSR, on every reset and on demand.
- Serves one-hot-indexed lookups onto a registered bus that is broadcast to all tiles in a row.
- Sits between the solver's row controller (requests) and the row's tiles (bus consumers).

Parameters:
- W, `GRID_LEN, pool size and bus/index width; legal range 2..64.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- IW, $clog2(W), width of the internal pool index; derived, not overridable.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears state and starts a fresh shuffle on release.
- shuffle_req  in  1  one-cycle pulse; requests a reshuffle; honoured only when ready=1.
- update  in  1  loads busvalue from the pool; honoured only when ready=1.
- rqindex  in  W  one-hot pool index; all-zero selects the zero value.
- busvalue  out  W  registered bus value.
- ready  out  1  pool is a stable permutation and lookups are served.

Behaviour:
- Reset values (async):
  - busvalue=0, ready=0.
  - FSM=INIT, LFSR=SEED, shuffle counter i=W-1.
- The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11 (mask 16'hB400). It advances every cycle in every state except during reset.
- FSM states:
  - INIT (1 cycle): pool[k] = 1<<k for all k; i=W-1; then SHUF.
  - SHUF: draw j = LFSR[IW-1:0].
    - If j<=i: swap pool[i] and pool[j]; i=i-1.
    - Else: retry next cycle (rejection sampling); pool and i unchanged.
    - When a swap is done at i=1, go to READY.
    - A swap with j==i is legal and is a no-op.
  - READY: ready=1.
    - shuffle_req=1: i=W-1, go to SHUF, ready=0 next cycle. The pool is not reinitialised; the current permutation is reshuffled.
- Shuffle length:
  - Minimum is W-1 cycles in SHUF.
  - Maximum is unbounded in principle but bounded in practice, because the LFSR is maximal-length (period 65535).
  - Benches use a bound of 64*W cycles.
- Lookup:
  - update=1 and ready=1 in cycle N: busvalue = pool[idx] at edge N+1 (1-cycle latency).
  - idx is the position of the least-significant set bit of rqindex.
  - rqindex==0: busvalue=0.
  - Non-one-hot rqindex is defined, not undefined: the lowest set bit wins.
- Simultaneous update and shuffle_req in READY:
  - The lookup is served from the pre-shuffle pool.
  - The FSM then enters SHUF.
- update while ready=0: ignored; busvalue holds its last value. No error flag.
- shuffle_req while ready=0: ignored; not queued.
- Reset mid-SHUF: immediately returns to INIT state (async); a full new shuffle follows release. A partial pool is never exposed, because ready stays 0.
- Invariant: in every cycle the pool is a permutation of {1<<k : k=0..W-1}, because swaps preserve it.

Optional Feature:
- Macro ROWBIAS_PERM_ASSERT_EN.
- Defined: simulation-only concurrent assertions are compiled in:
  - the pool OR-reduction equals all-ones and every entry has $countones==1, checked every cycle in READY;
  - busvalue is either 0 or one-hot;
  - ready never rises without passing through SHUF.
  - Failure raises $error with the state and i.
- Undefined: no assertions; RTL behaviour is identical.

Decomposition:
- Package rowbias_pkg holds:
  - the state enum state_e {INIT, SHUF, READY};
  - the LFSR width constant (16) and tap mask 16'hB400;
  - the function lsb_index(vec) returning the priority index.
- Sub-module bias_lfsr holds the 16-bit Galois LFSR.
  - Parameter: SEED.
  - Ports: clock, reset, value[15:0].
  - It is free-running and reused by future per-column/per-block bias units.

Test Plan:
- W=9, SEED=16'hACE1: release reset → ready rises within 8..576 cycles. Then update with rqindex=1<<k for k=0..8 → nine distinct one-hot busvalues, each 1 cycle after its update, whose OR is 9'h1FF.
- After ready: rqindex=9'b0 with update → busvalue=0. rqindex=9'b000010100 → busvalue equals the result of rqindex=9'b000000100.
- update while ready=0 (mid-shuffle) → busvalue holds its prior value. shuffle_req mid-shuffle → no extra shuffle; ready rises once.
- shuffle_req and update in the same READY cycle → busvalue equals the pre-shuffle pool entry. ready=0 next cycle, then rises again, and the permutation is still valid.
- Assert reset for 1 cycle mid-SHUF, asynchronously between edges → busvalue=0 and ready=0 immediately. After release, the pool permutation matches the golden model for SEED=16'hACE1.
- Repeated reshuffles (100×) with ROWBIAS_PERM_ASSERT_EN defined → no assertion fires; each of the 9 pool positions takes at least 5 distinct values.

Source files
------------

// File: rtl/rowbias_pkg.sv
// Shared types and helpers for the row bias shuffler and related bias units.
package rowbias_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SHUF  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Position of the least-significant set bit; 0 for an all-zero vector.
  function automatic logic [5:0] lsb_index(input logic [63:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int k = 63; k >= 0; k--) begin
      if (vec[k]) idx = 6'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bias_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11), shared by the bias units.
module bias_lfsr
  import rowbias_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/rowbias_shuffler.sv
// Row bias bus: keeps a Fisher-Yates shuffled pool of W one-hot values and serves lookups.
// Define ROWBIAS_PERM_ASSERT_EN to compile in simulation-only permutation assertions.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module rowbias_shuffler
  import rowbias_pkg::*;
#(
  parameter int                W    = `GRID_LEN,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shuffle_req,
  input  logic         update,
  input  logic [W-1:0] rqindex,
  output logic [W-1:0] busvalue,
  output logic         ready
);

  localparam int IW = $clog2(W);

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [W-1:0]      pool_q [W];
  logic [W-1:0]      pool_d [W];
  logic [W-1:0]      bus_q, bus_d;
  logic [LFSR_W-1:0] lfsr_val;
  logic [IW-1:0]     j;
  logic [IW-1:0]     lk_idx;
  logic              unused_lfsr_hi;

  bias_lfsr #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_val)
  );

  assign j              = lfsr_val[IW-1:0];
  assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:IW];
  assign lk_idx         = IW'(lsb_index(64'(rqindex)));

  // Draws with j > i are rejected and retried next cycle, keeping the permutation uniform.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pool_d  = pool_q;
    bus_d   = bus_q;
    case (state_q)
      INIT: begin
        for (int k = 0; k < W; k++) pool_d[k] = W'(1) << k;
        i_d     = IW'(W - 1);
        state_d = SHUF;
      end
      SHUF: begin
        if (j <= i_q) begin
          pool_d[i_q] = pool_q[j];
          pool_d[j]   = pool_q[i_q];
          if (i_q == IW'(1)) state_d = READY;
          else               i_d     = i_q - IW'(1);
        end
      end
      READY: begin
        if (update) bus_d = (rqindex == '0) ? '0 : pool_q[lk_idx];
        if (shuffle_req) begin
          i_d     = IW'(W - 1);
          state_d = SHUF;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      i_q     <= IW'(W - 1);
      bus_q   <= '0;
      for (int k = 0; k < W; k++) pool_q[k] <= W'(1) << k;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      bus_q   <= bus_d;
      pool_q  <= pool_d;
    end
  end

  assign busvalue = bus_q;
  assign ready    = (state_q == READY);

`ifdef ROWBIAS_PERM_ASSERT_EN
  logic [W-1:0] pool_or;
  logic         pool_onehot;

  always_comb begin
    pool_or     = '0;
    pool_onehot = 1'b1;
    for (int k = 0; k < W; k++) begin
      pool_or = pool_or | pool_q[k];
      if ($countones(pool_q[k]) != 1) pool_onehot = 1'b0;
    end
  end

  a_pool_perm: assert property (@(posedge clock) disable iff (reset)
      (state_q == READY) |-> (pool_or == '1 && pool_onehot))
    else $error("rowbias: pool not a permutation, state=%0d i=%0d", state_q, i_q);

  a_bus_onehot: assert property (@(posedge clock) disable iff (reset)
      (busvalue == '0 || $onehot(busvalue)))
    else $error("rowbias: busvalue not one-hot, state=%0d i=%0d", state_q, i_q);

  a_ready_via_shuf: assert property (@(posedge clock) disable iff (reset)
      $rose(ready) |-> ($past(state_q) == SHUF))
    else $error("rowbias: ready rose outside SHUF, state=%0d i=%0d", state_q, i_q);
`endif

endmodule

// File: tb/tb_rowbias_shuffler.sv
// Randomized bench for rowbias_shuffler (W=9) against a whole-shuffle behavioural model.
module tb_rowbias_shuffler;

  localparam int          W     = 9;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          BOUND = 64 * W;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         shuffle_req = 1'b0;
  logic         update = 1'b0;
  logic [W-1:0] rqindex = '0;
  logic [W-1:0] busvalue;
  logic         ready;

  int vectors = 0;
  int miscompares = 0;
  bit run_compare = 1'b0;

  logic [W-1:0] gold [W];

  always #5 clock = ~clock;

  rowbias_shuffler #(.W(W), .SEED(SEED)) dut (
    .clock       (clock),
    .reset       (reset),
    .shuffle_req (shuffle_req),
    .update      (update),
    .rqindex     (rqindex),
    .busvalue    (busvalue),
    .ready       (ready)
  );

  // Reference model: pool held as a packed array, each shuffle computed in one go.
  logic [15:0]          m_lfsr;
  logic [W-1:0][W-1:0]  m_pool;
  logic [W-1:0][W-1:0]  m_pending;
  logic [W-1:0]         m_bus;
  bit                   m_ready;
  bit                   m_init;
  int                   m_count;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [W-1:0][W-1:0] identity_pool();
    logic [W-1:0][W-1:0] p;
    for (int k = 0; k < W; k++) p[k] = W'(1) << k;
    return p;
  endfunction

  // Fisher-Yates with rejection, one LFSR draw per cycle; n returns cycles spent.
  function automatic logic [W-1:0][W-1:0] shuffle_pool(input logic [W-1:0][W-1:0] p_in,
                                                       input logic [15:0] l0, output int n);
    logic [W-1:0][W-1:0] p;
    logic [W-1:0] t;
    logic [15:0] l;
    int i, j;
    p = p_in; l = l0; i = W - 1; n = 0;
    while (i >= 1 && n < 100000) begin
      j = int'(l) % (1 << $clog2(W));
      n++;
      if (j <= i) begin
        t = p[i]; p[i] = p[j]; p[j] = t;
        i--;
      end
      l = lfsr_next(l);
    end
    return p;
  endfunction

  function automatic logic [W-1:0] lookup(input logic [W-1:0][W-1:0] p, input logic [W-1:0] r);
    for (int k = 0; k < W; k++) if (r[k]) return p[k];
    return '0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr  <= SEED;
      m_ready <= 1'b0;
      m_bus   <= '0;
      m_init  <= 1'b1;
      m_count <= 0;
    end else begin
      automatic logic [15:0] l_next = lfsr_next(m_lfsr);
      automatic int n = 0;
      m_lfsr <= l_next;
      if (m_init) begin
        m_init    <= 1'b0;
        m_pool    <= identity_pool();
        m_pending <= shuffle_pool(identity_pool(), l_next, n);
        m_count   <= n;
        m_ready   <= 1'b0;
      end else if (m_ready) begin
        if (update) m_bus <= lookup(m_pool, rqindex);
        if (shuffle_req) begin
          m_pending <= shuffle_pool(m_pool, l_next, n);
          m_count   <= n;
          m_ready   <= 1'b0;
        end
      end else begin
        if (m_count == 1) begin
          m_ready <= 1'b1;
          m_pool  <= m_pending;
        end
        m_count <= m_count - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d at %0t", name, actual, lo, hi, $time);
    end
  endtask

  // Called at a negedge; holds inputs across one rising edge and returns at the next negedge.
  task automatic applyStimulus(input logic upd, input logic sreq, input logic [W-1:0] rq);
    update      = upd;
    shuffle_req = sreq;
    rqindex     = rq;
    @(negedge clock);
    update      = 1'b0;
    shuffle_req = 1'b0;
  endtask

  task automatic wait_ready(output int cycles, input bit noise);
    cycles = 0;
    while (!ready && cycles < BOUND + 8) begin
      if (noise) applyStimulus(1'($urandom), 1'($urandom), W'($urandom));
      else       @(negedge clock);
      cycles++;
    end
    if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
  endtask

  always @(negedge clock) begin
    if (run_compare) begin
      checkOutput("ready_vs_model", 32'(ready), 32'(m_ready));
      checkOutput("bus_vs_model", 32'(busvalue), 32'(m_bus));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [W-1:0] acc;
    logic [W-1:0] seen [W];

    // Hand-derived first shuffle for SEED=16'hACE1 (17 SHUF cycles).
    gold[0] = 9'h100; gold[1] = 9'h040; gold[2] = 9'h020;
    gold[3] = 9'h002; gold[4] = 9'h004; gold[5] = 9'h010;
    gold[6] = 9'h008; gold[7] = 9'h080; gold[8] = 9'h001;
    for (int k = 0; k < W; k++) seen[k] = '0;

    run_compare = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_bus", 32'(busvalue), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);

    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("lfsr_step1", 32'(dut.u_lfsr.value), 32'h0000E270);
    checkOutput("model_lfsr_step1", 32'(m_lfsr), 32'h0000E270);
    @(posedge clock); #1;
    checkOutput("lfsr_step2", 32'(dut.u_lfsr.value), 32'h00007138);
    @(negedge clock);
    wait_ready(cyc, 1'b0);
    checkOutput("first_shuffle_len", 32'(cyc + 1), 32'd17);
    checkRange("first_shuffle_bound", cyc + 1, W - 1, BOUND);

    acc = '0;
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b1, 1'b0, W'(1) << k);
      checkOutput($sformatf("gold_pos%0d", k), 32'(busvalue), 32'(gold[k]));
      acc = acc | busvalue;
    end
    checkOutput("pool_or", 32'(acc), 32'h1FF);

    applyStimulus(1'b1, 1'b0, 9'b000000000);
    checkOutput("zero_index", 32'(busvalue), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'b000010100);
    checkOutput("lowest_bit_wins", 32'(busvalue), 32'(gold[2]));
    applyStimulus(1'b1, 1'b0, 9'b000000001);
    checkOutput("pos0_again", 32'(busvalue), 32'(gold[0]));
    applyStimulus(1'b1, 1'b0, 9'b000000100);
    checkOutput("single_bit_pos2", 32'(busvalue), 32'(gold[2]));

    applyStimulus(1'b1, 1'b1, 9'b000001000);
    checkOutput("simul_preshuffle_bus", 32'(busvalue), 32'(gold[3]));
    checkOutput("simul_ready_drop", 32'(ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'h1FF);
    checkOutput("hold_while_busy", 32'(busvalue), 32'(gold[3]));
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, 9'h100);
    checkOutput("hold_while_busy2", 32'(busvalue), 32'(gold[3]));
    wait_ready(cyc, 1'b0);
    repeat (4) begin
      @(negedge clock);
      checkOutput("ready_stays", 32'(ready), 32'd1);
    end
    acc = '0;
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b1, 1'b0, W'(1) << k);
      checkOutput($sformatf("reshuf_pos%0d", k), 32'(busvalue), 32'(m_pool[k]));
      acc = acc | busvalue;
    end
    checkOutput("reshuf_pool_or", 32'(acc), 32'h1FF);

    applyStimulus(1'b0, 1'b1, '0);
    repeat (3) @(negedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_bus", 32'(busvalue), 32'd0);
    checkOutput("async_reset_ready", 32'(ready), 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("lfsr_after_reset", 32'(dut.u_lfsr.value), 32'h0000E270);
    @(negedge clock);
    wait_ready(cyc, 1'b0);
    checkOutput("reset_shuffle_len", 32'(cyc), 32'd17);
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b1, 1'b0, W'(1) << k);
      checkOutput($sformatf("post_reset_gold%0d", k), 32'(busvalue), 32'(gold[k]));
    end

    for (int r = 0; r < 100; r++) begin
      applyStimulus(1'b0, 1'b1, '0);
      wait_ready(cyc, 1'b1);
      for (int k = 0; k < W; k++) begin
        applyStimulus(1'b1, 1'b0, W'(1) << k);
        seen[k] = seen[k] | busvalue;
      end
      applyStimulus(1'b1, 1'($urandom), W'($urandom));
      wait_ready(cyc, 1'b0);
    end
    for (int k = 0; k < W; k++)
      checkRange($sformatf("diversity_pos%0d", k), $countones(seen[k]), 5, W);

    @(negedge clock);
    run_compare = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
